// File: rtl/sm_status_pio_in.sv
// Avalon-MM status input port: synchronizes and glitch-filters external status
// lines, latches edges into a W1C register and raises a maskable level interrupt.
module sm_status_pio_in #(
  parameter int WIDTH         = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int EDGE_TYPE     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [7:0] CNT_LAST = 8'(FILTER_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [7:0]       r_cnt [WIDTH];
  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] r_level_d;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] r_irqmask;
  logic [31:0]      r_readdata;
  logic             r_irq;

  logic             w_wr;
  logic             w_rd;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_rd     = chipselect & ~read_n;
  assign w_clr    = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign w_unused = &{1'b0, writedata};

  // NOTE: every always_comb assigns defaults first so no path leaves a variable unassigned (no latch).
  always_comb begin
    w_edge = '0;
    case (EDGE_TYPE)
      0:       w_edge = r_level & ~r_level_d;
      1:       w_edge = ~r_level & r_level_d;
      default: w_edge = r_level ^ r_level_d;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      2'd0:    w_rdata[WIDTH-1:0] = r_level;
      2'd2:    w_rdata[WIDTH-1:0] = r_irqmask;
      2'd3:    w_rdata[WIDTH-1:0] = r_edgecap;
      default: w_rdata = '0;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values,
  // which is also what makes a same-cycle read return the pre-write register value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_level    <= '0;
      r_level_d  <= '0;
      r_edgecap  <= '0;
      r_irqmask  <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
      // NOTE: the counter array is plain flops, not a RAM, so resetting it is cheap and required.
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1   <= in_port;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;

      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_level[i] <= r_sync2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end

      // A freshly detected edge beats a simultaneous software clear.
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;

      if (w_wr && address == 2'd2) r_irqmask <= writedata[WIDTH-1:0];
      if (w_rd)                    r_readdata <= w_rdata;

      r_irq <= |(r_edgecap & r_irqmask);
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_sm_status_pio_in.sv
// Directed bench for sm_status_pio_in: reads push expected data into a scoreboard
// queue, a monitor pops and compares when readdata becomes valid.
module tb_sm_status_pio_in;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [1:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_pend = 1'b0;

  sm_status_pio_in #(.WIDTH(2), .FILTER_CYCLES(4), .EDGE_TYPE(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Read strobe captured on a rising edge -> readdata valid for the following cycle.
  always @(posedge clk) rd_pend <= !reset && chipselect && !read_n;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", readdata, 32'hDEAD_BEEF);
      end else begin
        check(name_q.pop_front(), readdata, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    exp_q.push_back(exp);
    name_q.push_back(name);
    tick(1);
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_rw(input logic [1:0] a, input logic [31:0] d, input logic [31:0] exp,
                        input string name);
    address = a; chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0; writedata = d;
    exp_q.push_back(exp);
    name_q.push_back(name);
    tick(1);
    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1; writedata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    writedata = '0; in_port = 2'b00;
    tick(3);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_readdata", readdata, 32'd0);
    reset = 1'b0;
    bus_read(2'd0, 32'h0, "reset_data");
    bus_read(2'd2, 32'h0, "reset_irqmask");
    bus_read(2'd3, 32'h0, "reset_edgecap");

    // Filter latency: level changes on the 6th edge after in_port changes.
    in_port = 2'b11;
    tick(5);
    bus_read(2'd0, 32'h0, "data_before_latency");
    bus_read(2'd0, 32'h3, "data_after_latency");
    bus_read(2'd3, 32'h3, "edgecap_both_rise");
    check("irq_masked", {31'd0, irq}, 32'd0);
    bus_write(2'd3, 32'h3);
    bus_read(2'd3, 32'h0, "edgecap_cleared");

    // Mask bit 0, then produce a fresh rising edge on it.
    in_port = 2'b10;
    tick(8);
    bus_write(2'd2, 32'h1);
    bus_read(2'd3, 32'h0, "falling_not_captured");
    in_port = 2'b11;
    tick(7);
    check("irq_lags_edgecap", {31'd0, irq}, 32'd0);
    tick(1);
    check("irq_asserted", {31'd0, irq}, 32'd1);
    bus_write(2'd3, 32'h1);
    check("irq_one_cycle_after_w1c", {31'd0, irq}, 32'd1);
    tick(1);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    bus_read(2'd3, 32'h0, "edgecap0_w1c");

    // Glitch rejection on bit 1, then a pulse long enough to be accepted.
    in_port = 2'b01;
    tick(8);
    in_port = 2'b11;
    tick(3);
    in_port = 2'b01;
    tick(10);
    bus_read(2'd0, 32'h1, "glitch_data");
    bus_read(2'd3, 32'h0, "glitch_edgecap");
    in_port = 2'b11;
    tick(5);
    in_port = 2'b01;
    tick(12);
    bus_read(2'd0, 32'h1, "pulse_data_settled");
    bus_read(2'd3, 32'h2, "pulse_edgecap1");
    check("irq_bit1_unmasked", {31'd0, irq}, 32'd0);
    bus_write(2'd3, 32'h2);

    // Set edgecap[0], then W1C it on the exact cycle a new rising edge is detected.
    in_port = 2'b00;
    tick(8);
    in_port = 2'b01;
    tick(12);
    in_port = 2'b00;
    tick(10);
    check("irq_before_race", {31'd0, irq}, 32'd1);
    in_port = 2'b01;
    tick(6);
    bus_write(2'd3, 32'h1);
    check("irq_race_t1", {31'd0, irq}, 32'd1);
    tick(2);
    check("irq_race_t3", {31'd0, irq}, 32'd1);
    bus_read(2'd3, 32'h1, "edgecap_set_wins");

    // Read-only and reserved addresses, irqmask width, read-during-write.
    tick(4);
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd0, 32'h1, "data_write_ignored");
    bus_read(2'd1, 32'h0, "reserved_reads_zero");
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd2, 32'h3, "irqmask_width");
    bus_rw(2'd2, 32'h0, 32'h3, "read_during_write");
    bus_read(2'd2, 32'h0, "irqmask_after_rw");
    bus_write(2'd2, 32'h1);
    tick(2);
    check("irq_before_reset", {31'd0, irq}, 32'd1);

    // Reset while bit 1 is mid-filter and irq is high.
    in_port = 2'b11;
    tick(4);
    reset = 1'b1;
    tick(1);
    check("midreset_irq", {31'd0, irq}, 32'd0);
    check("midreset_readdata", readdata, 32'd0);
    reset = 1'b0;
    bus_read(2'd3, 32'h0, "midreset_edgecap");
    bus_read(2'd2, 32'h0, "midreset_irqmask");
    tick(10);
    bus_read(2'd3, 32'h3, "post_reset_rise");
    bus_read(2'd0, 32'h3, "post_reset_data");
    check("post_reset_irq", {31'd0, irq}, 32'd0);

    tick(3);
    if (exp_q.size() != 0) check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
